uart_message_bridge: RTL and testbench

//  Bidirectional message framer between a byte-wide UART core and message-level chat logic.
//  TX: accepts one message of up to MSG_BYTES bytes and feeds it to the UART one byte at a time.
//  RX: assembles received bytes into a message and presents it with its length.

---
 rtl/uart_bridge_pkg.sv | 9 +
 rtl/uart_msg_rx_assembler.sv | 68 ++++++
 rtl/uart_message_bridge.sv | 104 ++++++++++
 tb/tb_uart_message_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared state encodings, length-width helper and default terminator for the UART message bridge
package uart_bridge_pkg;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_e;
    typedef enum logic {R_COLLECT, R_HOLD} rx_state_e;
    localparam logic [7:0] DEF_TERM_CHAR = 8'h0D;
    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/uart_msg_rx_assembler.sv
// uart_msg_rx_assembler: builds left-aligned RX messages from UART byte strobes
// Ports: byte_in/byte_strobe from the UART receiver; rx_msg/rx_len/rx_msg_valid held until
// rx_msg_ready; rx_overrun pulses when a byte arrives while a message is held.
module uart_msg_rx_assembler
    import uart_bridge_pkg::*;
#(
    parameter int         MSG_BYTES      = 8,
    parameter bit         TERM_EN        = 1'b1,
    parameter logic [7:0] TERM_CHAR      = DEF_TERM_CHAR,
    parameter int         TIMEOUT_CYCLES = 0,
    parameter int         LEN_W          = len_w(MSG_BYTES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             byte_in,
    input  logic                   byte_strobe,
    output logic [8*MSG_BYTES-1:0] rx_msg,
    output logic [LEN_W-1:0]       rx_len,
    output logic                   rx_msg_valid,
    input  logic                   rx_msg_ready,
    output logic                   rx_overrun
);
    localparam int MW = 8 * MSG_BYTES;
    rx_state_e         state_q, state_d;
    logic [MW-1:0]     msg_q, msg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, base_cnt;
    logic [31:0]       gap_q, gap_d;
    logic              valid_q, valid_d, ovr_q, ovr_d;
    logic              hs, open, is_term, app, expire, close;
    // A handshake frees the buffer in the same cycle, so a coinciding strobe starts the next message.
    always_comb begin
        hs       = valid_q && rx_msg_ready;
        open     = state_q == R_COLLECT || hs;
        base_cnt = hs ? '0 : cnt_q;
        is_term  = TERM_EN && byte_in == TERM_CHAR;
        app      = open && byte_strobe && !is_term;
        cnt_d    = base_cnt + LEN_W'(app);
        msg_d    = hs ? '0 : msg_q;
        if (app) msg_d = msg_d | (MW'(byte_in) << (8 * (MSG_BYTES - 1 - int'(base_cnt))));
        gap_d    = (!open || byte_strobe || cnt_d == '0) ? '0 : gap_q + 32'd1;
        expire   = TIMEOUT_CYCLES != 0 && open && !byte_strobe && base_cnt != '0 && gap_d == 32'(TIMEOUT_CYCLES);
        close    = open && ((byte_strobe && is_term && base_cnt != '0) || cnt_d == LEN_W'(MSG_BYTES) || expire);
        state_d  = (close || !open) ? R_HOLD : R_COLLECT;
        valid_d  = state_d == R_HOLD;
        ovr_d    = !open && byte_strobe;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= R_COLLECT;
            msg_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end
    assign rx_msg       = msg_q;
    assign rx_len       = cnt_q;
    assign rx_msg_valid = valid_q;
    assign rx_overrun   = ovr_q;
endmodule

// File: rtl/uart_message_bridge.sv
// uart_message_bridge: frames whole messages onto a byte-wide UART and reassembles received ones
// Ports: tx_msg/tx_len/tx_msg_valid/tx_msg_ready/tx_done message-side TX; Byte_Out/Load_Byte/
// byte_has_been_sent UART TX; Byte_In/byte_has_been_received UART RX; rx_msg/rx_len/
// rx_msg_valid/rx_msg_ready/rx_overrun message-side RX.
module uart_message_bridge
    import uart_bridge_pkg::*;
#(
    parameter int         MSG_BYTES      = 8,
    parameter bit         TERM_EN        = 1'b1,
    parameter logic [7:0] TERM_CHAR      = DEF_TERM_CHAR,
    parameter int         TIMEOUT_CYCLES = 0,
    localparam int        LEN_W          = len_w(MSG_BYTES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*MSG_BYTES-1:0] tx_msg,
    input  logic [LEN_W-1:0]       tx_len,
    input  logic                   tx_msg_valid,
    output logic                   tx_msg_ready,
    output logic                   tx_done,
    output logic [7:0]             Byte_Out,
    output logic                   Load_Byte,
    input  logic                   byte_has_been_sent,
    input  logic [7:0]             Byte_In,
    input  logic                   byte_has_been_received,
    output logic [8*MSG_BYTES-1:0] rx_msg,
    output logic [LEN_W-1:0]       rx_len,
    output logic                   rx_msg_valid,
    input  logic                   rx_msg_ready,
    output logic                   rx_overrun
);
    localparam int MW = 8 * MSG_BYTES;
    tx_state_e        tx_state_q, tx_state_d;
    logic [MW-1:0]    sh_q, sh_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             load_q, load_d, done_q, done_d;
    always_comb begin
        tx_state_d = tx_state_q;
        sh_d       = sh_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        byte_d     = byte_q;
        load_d     = 1'b0;
        done_d     = 1'b0;
        if (tx_state_q == T_IDLE && tx_msg_valid) begin
            sh_d       = tx_msg;
            len_d      = (tx_len == '0 || tx_len > LEN_W'(MSG_BYTES)) ? LEN_W'(MSG_BYTES) : tx_len;
            cnt_d      = '0;
            tx_state_d = T_SEND;
        end
        if (tx_state_q == T_SEND) begin
            byte_d     = sh_q[MW-1 -: 8];
            sh_d       = sh_q << 8;
            cnt_d      = cnt_q + LEN_W'(1);
            load_d     = 1'b1;
            tx_state_d = T_WAIT;
        end
        if (tx_state_q == T_WAIT && byte_has_been_sent) begin
            done_d     = cnt_q == len_q;
            tx_state_d = done_d ? T_IDLE : T_SEND;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= T_IDLE;
            sh_q       <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            byte_q     <= '0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            sh_q       <= sh_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            byte_q     <= byte_d;
            load_q     <= load_d;
            done_q     <= done_d;
        end
    end
    assign tx_msg_ready = tx_state_q == T_IDLE;
    assign tx_done      = done_q;
    assign Byte_Out     = byte_q;
    assign Load_Byte    = load_q;
    uart_msg_rx_assembler #(
        .MSG_BYTES     (MSG_BYTES),
        .TERM_EN       (TERM_EN),
        .TERM_CHAR     (TERM_CHAR),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .LEN_W         (LEN_W)
    ) u_rx (
        .clk         (clk),
        .reset_n     (reset_n),
        .byte_in     (Byte_In),
        .byte_strobe (byte_has_been_received),
        .rx_msg      (rx_msg),
        .rx_len      (rx_len),
        .rx_msg_valid(rx_msg_valid),
        .rx_msg_ready(rx_msg_ready),
        .rx_overrun  (rx_overrun)
    );
endmodule

// File: tb/tb_uart_message_bridge.sv
// tb_uart_message_bridge: directed and random checks of the bridge against a message-level model
module tb_uart_message_bridge;
    localparam int MB = 8;
    localparam int TO = 20;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] tx_msg = '0;
    logic [3:0]  tx_len = '0;
    logic        tx_msg_valid = 1'b0;
    logic        tx_msg_ready, tx_done, Load_Byte;
    logic [7:0]  Byte_Out;
    logic        byte_has_been_sent = 1'b0;
    logic [7:0]  Byte_In = '0;
    logic        byte_has_been_received = 1'b0;
    logic [63:0] rx_msg;
    logic [3:0]  rx_len;
    logic        rx_msg_valid, rx_overrun;
    logic        rx_msg_ready = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    // TX reference: bytes still to be loaded for the message in flight
    logic [7:0] txq[$];
    logic [7:0] obs_tx[$];
    bit busy = 0, outst = 0, acc_prev = 0;
    int ucnt = 0, nloads = 0, ndone = 0;
    // RX reference: bytes collected so far, idle cycles, and the held message
    logic [7:0] cur[$];
    bit rv = 0;
    int idle = 0, rlen = 0;
    logic [63:0] rmsg = '0;

    uart_message_bridge #(.MSG_BYTES(MB), .TERM_EN(1'b1), .TERM_CHAR(8'h0D), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .tx_msg(tx_msg), .tx_len(tx_len), .tx_msg_valid(tx_msg_valid), .tx_msg_ready(tx_msg_ready),
        .tx_done(tx_done), .Byte_Out(Byte_Out), .Load_Byte(Load_Byte),
        .byte_has_been_sent(byte_has_been_sent), .Byte_In(Byte_In),
        .byte_has_been_received(byte_has_been_received),
        .rx_msg(rx_msg), .rx_len(rx_len), .rx_msg_valid(rx_msg_valid),
        .rx_msg_ready(rx_msg_ready), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic close_msg();
        rv = 1;
        rlen = cur.size();
        rmsg = '0;
        foreach (cur[i]) rmsg[63-8*i -: 8] = cur[i];
    endtask

    task automatic cyc();
        bit s, r, ed, ov;
        logic [7:0] b;
        int l;
        byte_has_been_sent = (ucnt == 1) || (!busy && $urandom_range(0, 7) == 0);
        s = byte_has_been_received;
        b = Byte_In;
        r = rx_msg_ready;
        @(posedge clk);
        #1;
        ed = busy && byte_has_been_sent && outst && txq.size() == 0;
        if (acc_prev) chk("tx_load_after_accept", 64'(Load_Byte), 64'd1);
        acc_prev = 0;
        if (ed) begin
            busy = 0;
            outst = 0;
        end else begin
            if (byte_has_been_sent) outst = 0;
            if (!busy && tx_msg_valid) begin
                busy = 1;
                acc_prev = 1;
                nloads = 0;
                l = (tx_len == 0 || tx_len > MB) ? MB : int'(tx_len);
                for (int i = 0; i < l; i++) txq.push_back(tx_msg[63-8*i -: 8]);
            end
        end
        chk("tx_done", 64'(tx_done), 64'(ed));
        chk("tx_ready", 64'(tx_msg_ready), 64'(!busy));
        if (tx_done) ndone++;
        if (ucnt > 0) ucnt--;
        if (Load_Byte) begin
            chk("tx_load_pending", 64'(txq.size() != 0), 64'd1);
            if (txq.size() != 0) chk("tx_byte", 64'(Byte_Out), 64'(txq.pop_front()));
            obs_tx.push_back(Byte_Out);
            outst = 1;
            nloads++;
            ucnt = 3;
        end
        ov = rv && !r && s;
        if (rv && r) begin
            rv = 0;
            cur.delete();
            idle = 0;
        end
        if (!rv) begin
            if (s) begin
                idle = 0;
                if (b == 8'h0D) begin
                    if (cur.size() > 0) close_msg();
                end else begin
                    cur.push_back(b);
                    if (cur.size() == MB) close_msg();
                end
            end else if (cur.size() > 0) begin
                idle++;
                if (idle == TO) close_msg();
            end
        end
        chk("rx_valid", 64'(rx_msg_valid), 64'(rv));
        chk("rx_overrun", 64'(rx_overrun), 64'(ov));
        if (rv) begin
            chk("rx_msg", rx_msg, rmsg);
            chk("rx_len", 64'(rx_len), 64'(rlen));
        end
        byte_has_been_received = 0;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc();
    endtask

    task automatic rxb(input logic [7:0] b);
        Byte_In = b;
        byte_has_been_received = 1;
        cyc();
    endtask

    task automatic wait_tx();
        int k = 0;
        while (busy && k < 200) begin
            cyc();
            k++;
        end
        chk("tx_finish_bound", 64'(tx_msg_ready), 64'd1);
    endtask

    task automatic send_tx(input logic [63:0] m, input logic [3:0] l);
        wait_tx();
        tx_msg = m;
        tx_len = l;
        tx_msg_valid = 1;
        cyc();
        tx_msg_valid = 0;
    endtask

    task automatic handshake();
        rx_msg_ready = 1;
        cyc();
        rx_msg_ready = 0;
    endtask

    initial begin
        logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        int k;
        int quiet = 0;
        @(posedge clk);
        #1;
        chk("rst_load", 64'(Load_Byte), 64'd0);
        chk("rst_done", 64'(tx_done), 64'd0);
        chk("rst_byte_out", 64'(Byte_Out), 64'd0);
        chk("rst_rx_valid", 64'(rx_msg_valid), 64'd0);
        chk("rst_rx_msg", rx_msg, 64'd0);
        chk("rst_rx_len", 64'(rx_len), 64'd0);
        chk("rst_overrun", 64'(rx_overrun), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1;
        cyc();
        chk("rst_tx_ready", 64'(tx_msg_ready), 64'd1);
        // hello, 5 bytes
        obs_tx.delete();
        ndone = 0;
        send_tx(64'h68656C6C6F000000, 4'd5);
        wait_tx();
        chk("t1_loads", 64'(obs_tx.size()), 64'd5);
        for (int i = 0; i < 5; i++) chk("t1_byte", 64'(obs_tx[i]), 64'(hello[i]));
        chk("t1_done_count", 64'(ndone), 64'd1);
        // "hi" + CR
        rxb("h");
        idle_n(1);
        rxb("i");
        idle_n(1);
        rxb(8'h0D);
        chk("t2_valid", 64'(rx_msg_valid), 64'd1);
        chk("t2_len", 64'(rx_len), 64'd2);
        chk("t2_msg", rx_msg, 64'h6869_0000_0000_0000);
        handshake();
        chk("t2_cleared", 64'(rx_msg_valid), 64'd0);
        // full 8-byte message then overrun
        for (int i = 0; i < 8; i++) begin
            rxb(8'h30 + 8'(i));
            if (i < 7) idle_n(1);
        end
        chk("t3_valid", 64'(rx_msg_valid), 64'd1);
        chk("t3_len", 64'(rx_len), 64'd8);
        chk("t3_msg", rx_msg, 64'h3031_3233_3435_3637);
        rxb(8'h41);
        chk("t3_overrun", 64'(rx_overrun), 64'd1);
        chk("t3_msg_kept", rx_msg, 64'h3031_3233_3435_3637);
        idle_n(1);
        chk("t3_overrun_pulse", 64'(rx_overrun), 64'd0);
        handshake();
        // timeout closes after 20 idle cycles
        rxb("a");
        idle_n(1);
        rxb("b");
        idle_n(19);
        chk("t4_not_yet", 64'(rx_msg_valid), 64'd0);
        cyc();
        chk("t4_timeout_valid", 64'(rx_msg_valid), 64'd1);
        chk("t4_len", 64'(rx_len), 64'd2);
        chk("t4_msg", rx_msg, 64'h6162_0000_0000_0000);
        handshake();
        // byte coinciding with expiry wins
        rxb("a");
        idle_n(1);
        rxb("b");
        idle_n(19);
        rxb("c");
        chk("t4b_no_close", 64'(rx_msg_valid), 64'd0);
        idle_n(19);
        chk("t4b_not_yet", 64'(rx_msg_valid), 64'd0);
        cyc();
        chk("t4b_valid", 64'(rx_msg_valid), 64'd1);
        chk("t4b_len", 64'(rx_len), 64'd3);
        chk("t4b_msg", rx_msg, 64'h6162_6300_0000_0000);
        handshake();
        // leading CR ignored, strobe during handshake starts new message
        rxb(8'h0D);
        idle_n(1);
        chk("t5_lead_cr", 64'(rx_msg_valid), 64'd0);
        rxb("p");
        idle_n(1);
        rxb(8'h0D);
        chk("t5_p_len", 64'(rx_len), 64'd1);
        rx_msg_ready = 1;
        rxb("q");
        rx_msg_ready = 0;
        chk("t5_hs_valid", 64'(rx_msg_valid), 64'd0);
        chk("t5_hs_overrun", 64'(rx_overrun), 64'd0);
        rxb(8'h0D);
        chk("t5_q_len", 64'(rx_len), 64'd1);
        chk("t5_q_msg", rx_msg, 64'h7100_0000_0000_0000);
        handshake();
        send_tx({$urandom, $urandom}, 4'd0);
        wait_tx();
        chk("t5_len0_loads", 64'(nloads), 64'd8);
        // reset in the middle of TX byte 3 with an RX partial pending
        rxb("z");
        send_tx({$urandom, $urandom}, 4'd8);
        k = 0;
        while (nloads < 3 && k < 100) begin
            cyc();
            k++;
        end
        chk("t6_third_load", 64'(nloads), 64'd3);
        #2;
        reset_n = 0;
        byte_has_been_sent = 0;
        #1;
        chk("t6_rst_load", 64'(Load_Byte), 64'd0);
        chk("t6_rst_done", 64'(tx_done), 64'd0);
        chk("t6_rst_rx_msg", rx_msg, 64'd0);
        chk("t6_rst_rx_len", 64'(rx_len), 64'd0);
        txq.delete();
        busy = 0;
        outst = 0;
        acc_prev = 0;
        ucnt = 0;
        cur.delete();
        rv = 0;
        idle = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1;
        ndone = 0;
        cyc();
        chk("t6_ready", 64'(tx_msg_ready), 64'd1);
        idle_n(30);
        chk("t6_no_done", 64'(ndone), 64'd0);
        rxb("x");
        idle_n(1);
        rxb(8'h0D);
        chk("t6_rx_len", 64'(rx_len), 64'd1);
        chk("t6_rx_msg", rx_msg, 64'h7800_0000_0000_0000);
        handshake();
        // random concurrent traffic
        for (int c = 0; c < 1500; c++) begin
            if (!busy && $urandom_range(0, 9) == 0) begin
                tx_msg = {$urandom, $urandom};
                tx_len = 4'($urandom_range(0, 15));
                tx_msg_valid = 1;
            end
            if (quiet > 0) quiet--;
            else if ($urandom_range(0, 39) == 0) quiet = 25;
            else if ($urandom_range(0, 2) == 0) begin
                Byte_In = ($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom);
                byte_has_been_received = 1;
            end
            rx_msg_ready = $urandom_range(0, 3) == 0;
            cyc();
            tx_msg_valid = 0;
        end
        rx_msg_ready = 0;
        wait_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
